// File: rtl/sram_pkg.sv
// Shared definitions for the 16-bit asynchronous SRAM data-memory responder.
package sram_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ADDR_BASE_DEF = 1024;
    localparam int HOLD_DEF      = 2;
    localparam int SRAM_DW       = 16;

    // Word index relative to the SRAM base; wraps modulo 2^32 below the base.
    function automatic logic [31:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction
endpackage

// File: rtl/sram_model.sv
// Behavioural 2^AW x 16 SRAM: combinational read, write while we_n is low at each clock edge.
module sram_model
    import sram_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    input  logic [SRAM_DW-1:0] din,
    input  logic               we_n,
    output logic [SRAM_DW-1:0] dout
);
    logic [SRAM_DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (!we_n) mem[addr] <= din;
    end

    assign dout = mem[addr];
endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage word responder: each 32-bit access becomes two held half-word SRAM cycles.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_BASE = ADDR_BASE_DEF,
    parameter int HOLD      = HOLD_DEF,
    parameter int SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);
    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    state_t             state, nxt;
    logic [3:0]         cnt;
    logic               is_wr;
    logic [SRAM_AW-2:0] idx;
    logic [31:0]        wdata;
    logic               req, last, busy;

    assign req  = rd_en | wr_en;
    assign busy = (state == LO) || (state == HI);
    assign last = busy && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (busy && !last) ? cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = LO;
            LO:      if (last) nxt = HI;
            HI:      if (last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operation is captured once on IDLE->LO; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                is_wr <= wr_en;
                idx   <= (SRAM_AW-1)'(word_idx(address, 32'(ADDR_BASE)));
                wdata <= write_data;
            end
            if (!is_wr && last) begin
                if (state == LO) read_data[15:0]  <= sram_dq_in;
                else             read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // we_n rises on the last held cycle so data stays valid past the strobe edge.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (busy) begin
            sram_addr = {idx, state == HI};
            if (is_wr) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
                sram_we_n   = last;
            end
        end
        ready = ((state == IDLE) && !req) || (state == DONE);
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench: directed vector table, corner sequences, then random ops against a word-level model.
module tb_sram_ctrl;
    localparam int ADDR_BASE = 1024;
    localparam int HOLD      = 2;
    localparam int SRAM_AW   = 10;
    localparam int LAT       = 2*HOLD + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               rd_en, wr_en;
    logic [31:0]        address, write_data, read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out, sram_dq_in;
    logic               sram_dq_oe, sram_we_n;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_BASE(ADDR_BASE), .HOLD(HOLD), .SRAM_AW(SRAM_AW)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_model #(.AW(SRAM_AW)) u_mem (
        .clk(clk), .addr(sram_addr), .din(sram_dq_out), .we_n(sram_we_n), .dout(sram_dq_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; inputs are scrambled mid-operation to prove they were latched.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output int lat, output int wlow);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        lat = 0; wlow = 0;
        #1 chk("ready_req_cycle0", {31'b0, ready}, 32'd0);
        do begin
            @(posedge clk); #1;
            lat++;
            if (!sram_we_n) wlow++;
            if (lat == 1) begin address = ~a; write_data = ~d; end
        end while (!ready && lat < 50);
        if (!ready) chk("op_timeout", 32'd0, 32'd1);
        rdata = read_data;
        rd_en = 0; wr_en = 0;
        @(posedge clk); #1;
        chk("ready_idle_after", {31'b0, ready}, 32'd1);
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata, exp_rd;
        int          lo;
    } vec_t;

    vec_t vecs[8];
    bit [31:0] ref_mem [int];

    initial begin
        logic [31:0] rdata, last_rd;
        int lat, wlow;

        vecs[0] = '{0, 1, 1024, 32'hDEADBEEF, 32'h0,        0};
        vecs[1] = '{1, 0, 1024, 32'h0,        32'hDEADBEEF, 0};
        vecs[2] = '{0, 1, 1036, 32'h12345678, 32'hDEADBEEF, 6};
        vecs[3] = '{1, 0, 1037, 32'h0,        32'h12345678, 6};
        vecs[4] = '{1, 1, 1028, 32'h0000A5A5, 32'h12345678, 2};
        vecs[5] = '{1, 0, 1028, 32'h0,        32'h0000A5A5, 2};
        vecs[6] = '{0, 1, 1020, 32'hCAFEF00D, 32'h0000A5A5, 'h3FE};
        vecs[7] = '{1, 0, 1023, 32'h0,        32'hCAFEF00D, 'h3FE};

        rst = 0; rd_en = 1; wr_en = 0; address = 1024; write_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_req", {31'b0, ready}, 32'd0);
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        rd_en = 0;
        #1 chk("rst_ready_idle", {31'b0, ready}, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, ready}, 32'd1);

        foreach (vecs[i]) begin
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, lat, wlow);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("v%0d_read_data", i), rdata, vecs[i].exp_rd);
            chk($sformatf("v%0d_we_low_cycles", i), 32'(wlow), vecs[i].wr ? 32'(2*(HOLD-1)) : 32'd0);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_mem_lo", i), {16'h0, u_mem.mem[vecs[i].lo]}, {16'h0, vecs[i].wdata[15:0]});
                chk($sformatf("v%0d_mem_hi", i), {16'h0, u_mem.mem[vecs[i].lo+1]}, {16'h0, vecs[i].wdata[31:16]});
            end
        end

        // Back-to-back reads with the request held through DONE.
        begin
            int p1 = -1, p2 = -1;
            rd_en = 1; address = 1024;
            for (int c = 1; c <= 40 && p2 < 0; c++) begin
                @(posedge clk); #1;
                if (ready) begin
                    if (p1 < 0) begin
                        p1 = c;
                        chk("b2b_data0", read_data, 32'hDEADBEEF);
                        address = 1028;
                    end else begin
                        p2 = c;
                        chk("b2b_data1", read_data, 32'h0000A5A5);
                        rd_en = 0;
                    end
                end
            end
            chk("b2b_first_done", 32'(p1), 32'(LAT));
            chk("b2b_spacing", 32'(p2 - p1), 32'(LAT + 1));
            @(posedge clk); #1;
        end

        // Reset during the high half of a write.
        wr_en = 1; address = 1040; write_data = 32'h11112222;
        repeat (HOLD + 1) @(posedge clk);
        #1;
        chk("midhi_addr", 32'(sram_addr), 32'd9);
        chk("midhi_we_n", {31'b0, sram_we_n}, 32'd0);
        wr_en = 0; rst = 0;
        #1;
        chk("midhi_rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("midhi_rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("midhi_rst_addr", 32'(sram_addr), 32'd0);
        chk("midhi_rst_ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        do_op(1, 0, 1024, 0, rdata, lat, wlow);
        chk("after_rst_latency", 32'(lat), 32'(LAT));
        chk("after_rst_data", rdata, 32'hDEADBEEF);
        last_rd = rdata;

        // Random ops over words 32..47 against a word-granular reference.
        for (int n = 0; n < 60; n++) begin
            int k;
            logic rd, wr;
            logic [31:0] a, d, exp;
            k  = 32 + int'($urandom_range(0, 15));
            a  = 32'(ADDR_BASE + 4*k) + 32'($urandom_range(0, 3));
            d  = $urandom;
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0) ? 1'b1 : ~rd;
            if (!wr && !ref_mem.exists(k)) wr = 1'b1;
            do_op(rd, wr, a, d, rdata, lat, wlow);
            if (wr) ref_mem[k] = d;
            else last_rd = ref_mem[k];
            exp = last_rd;
            chk($sformatf("rnd%0d_data", n), rdata, exp);
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(LAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
